// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers: round-robin arbitration with
// optional packet locking, send/busy handshake, per-requester acknowledge.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 0,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 timeout_err
);

  // state   | meaning
  // S_IDLE  | no frame in flight; arbitrate once the transmitter is free
  // S_START | tx_send high, waiting for busy (bounded by START_TIMEOUT)
  // S_WAIT  | byte accepted, waiting for the frame to finish
  // S_GAP   | enforced idle spacing before the next arbitration

  localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 lock_q, lock_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 tx_send_q, tx_send_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 timeout_q, timeout_d;

  logic                 rr_found;
  logic [PW-1:0]        rr_idx;
  logic [PW-1:0]        win_idx;

  // Round-robin search starting just after the last owner.
  always_comb begin
    int idx;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    grant_d   = grant_q;
    ack_d     = '0;
    tx_send_d = tx_send_q;
    tx_data_d = tx_data_q;
    timeout_d = 1'b0;
    win_idx   = rr_idx;

    case (state_q)
      S_IDLE: begin
        if (!tx_busy && (req != '0)) begin
          // A locked owner keeps the transmitter only while it still requests.
          if (lock_q && req[ptr_q]) begin
            win_idx = ptr_q;
          end else begin
            lock_d  = 1'b0;
            win_idx = rr_idx;
          end
          tx_data_d        = req_data[8*win_idx +: 8];
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ptr_d            = win_idx;
          tx_send_d        = 1'b1;
          cnt_d            = '0;
          state_d          = S_START;
        end
      end

      S_START: begin
        if (tx_busy) begin
          tx_send_d    = 1'b0;
          ack_d[ptr_q] = 1'b1;
          lock_d       = ~req_last[ptr_q];
          cnt_d        = '0;
          state_d      = S_WAIT;
        end else if (cnt_q == TO_LAST) begin
          tx_send_d = 1'b0;
          timeout_d = 1'b1;
          lock_d    = 1'b0;
          grant_d   = '0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (!tx_busy) begin
          cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            if (!lock_q) grant_d = '0;
          end
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!lock_q) grant_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        tx_send_d = 1'b0;
        grant_d   = '0;
        lock_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= PW'(NUM_REQ - 1);
      lock_q    <= 1'b0;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      timeout_q <= timeout_d;
    end
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign tx_send     = tx_send_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter, per-requester byte sources,
// and an ack scoreboard fed with the expected owner/byte order.
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NR-1:0]   req = '0, req_last = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   ack, grant;
  logic            tx_send, timeout_err;
  logic [7:0]      tx_data;
  logic            tx_busy = 1'b0;

  logic [NR-1:0]   g_req = '0, g_last = '0;
  logic [8*NR-1:0] g_data = '0;
  logic [NR-1:0]   g_ack, g_grant;
  logic            g_send, g_to;
  logic [7:0]      g_txd;
  logic            g_busy = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(0), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .req_data(req_data),
    .ack(ack), .grant(grant), .tx_send(tx_send), .tx_data(tx_data),
    .tx_busy(tx_busy), .timeout_err(timeout_err));

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(50), .START_TIMEOUT(1024)) dut_g (
    .clk(clk), .rst_n(rst_n), .req(g_req), .req_last(g_last), .req_data(g_data),
    .ack(g_ack), .grant(g_grant), .tx_send(g_send), .tx_data(g_txd),
    .tx_busy(g_busy), .timeout_err(g_to));

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] idx; logic [7:0] data; } exp_t;
  typedef struct { logic [3:0] req; int n; logic [7:0] order; } vec_t;

  exp_t       exp_q[$];
  logic [8:0] src_q [NR][$];
  vec_t       vecs [6];

  int n_vec = 0, n_bad = 0;
  bit tx_auto = 1'b1;
  int busy_len = 6, busy_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic present(input int i);
    logic [8:0] s;
    if (src_q[i].size() > 0) begin
      s = src_q[i].pop_front();
      req_data[8*i +: 8] = s[7:0];
      req_last[i] = s[8];
      req[i] = 1'b1;
    end else begin
      req[i] = 1'b0;
    end
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l);
    src_q[i].push_back({l, d});
    if (!req[i]) present(i);
  endtask

  task automatic push_exp(input int i, input logic [7:0] d);
    exp_t e;
    e.idx  = 2'(i);
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] dbyte(input int v, input int i);
    return 8'(40 + 16*v + i);
  endfunction

  task automatic drain(input string name);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy && !tx_send) break;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk({name, "_grant_idle"}, grant, 0);
  endtask

  // Behavioural uart_tx: accepts a byte one half-cycle after send, busy for busy_len.
  initial forever begin
    @(negedge clk);
    if (tx_auto) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end else if (tx_send && !tx_busy) begin
        tx_busy   = 1'b1;
        busy_left = busy_len;
      end
    end
  end

  // Ack scoreboard; acked requesters move on to their next queued byte.
  initial forever begin
    @(negedge clk);
    if (rst_n && ack != '0) begin
      chk("ack_onehot", $countones(ack), 1);
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", ack, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_idx", ack, 4'b0001 << e.idx);
        chk("tx_byte", tx_data, e.data);
        chk("ack_grant", grant, 4'b0001 << e.idx);
      end
      for (int i = 0; i < NR; i++) if (ack[i]) present(i);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, hi;
    bit saw;

    vecs[0] = '{req: 4'b0001, n: 1, order: 8'h00};
    vecs[1] = '{req: 4'b1111, n: 4, order: 8'h39};
    vecs[2] = '{req: 4'b0110, n: 2, order: 8'h09};
    vecs[3] = '{req: 4'b1001, n: 2, order: 8'h03};
    vecs[4] = '{req: 4'b1010, n: 2, order: 8'h0D};
    vecs[5] = '{req: 4'b0101, n: 2, order: 8'h08};

    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {ack, grant, tx_send, tx_data, timeout_err}, 0);
    chk("reset_outputs_g", {g_ack, g_grant, g_send, g_txd, g_to}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Gap spacing on the GAP_CYCLES=50 instance.
    g_last = 4'b0011;
    g_data = 32'h0000_B1B0;
    @(negedge clk);
    g_req = 4'b0011;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; if (g_send) break; end
    chk("gap_first_send", g_send, 1);
    chk("gap_first_grant", g_grant, 4'b0001);
    chk("gap_first_data", g_txd, 8'hB0);
    @(negedge clk); g_busy = 1'b1;
    @(posedge clk); #1;
    chk("gap_ack0", g_ack, 4'b0001);
    @(negedge clk); g_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    g_busy = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin @(posedge clk); #1; cnt++; if (g_send) break; end
    chk("gap_spacing", cnt, 52);
    chk("gap_second_grant", g_grant, 4'b0010);
    chk("gap_second_data", g_txd, 8'hB1);
    @(negedge clk); g_busy = 1'b1;
    @(posedge clk); #1;
    chk("gap_ack1", g_ack, 4'b0010);
    @(negedge clk); g_req = '0;
    repeat (2) @(negedge clk);
    g_busy = 1'b0;
    repeat (55) @(negedge clk);
    chk("gap_grant_release", g_grant, 0);

    // Table-driven round-robin vectors, one byte per requester, all packet ends.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      for (int k = 0; k < vecs[v].n; k++) begin
        logic [1:0] ix;
        ix = vecs[v].order[2*k +: 2];
        push_exp(int'(ix), dbyte(v, int'(ix)));
      end
      for (int i = 0; i < NR; i++) if (vecs[v].req[i]) load(i, dbyte(v, i), 1'b1);
      drain($sformatf("vec%0d", v));
    end

    // Held requests from a fresh pointer: 0,1,2,3,0.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    push_exp(0, 8'h10); push_exp(1, 8'h11); push_exp(2, 8'h12);
    push_exp(3, 8'h13); push_exp(0, 8'h10);
    load(0, 8'h10, 1'b1); load(0, 8'h10, 1'b1); load(1, 8'h11, 1'b1);
    load(2, 8'h12, 1'b1); load(3, 8'h13, 1'b1);
    drain("rr_held");

    // Packet lock: requester 1 keeps the transmitter for three bytes.
    @(negedge clk);
    push_exp(1, 8'h31); push_exp(1, 8'h32); push_exp(1, 8'h33);
    push_exp(2, 8'h34); push_exp(0, 8'h30);
    load(0, 8'h30, 1'b1); load(1, 8'h31, 1'b0); load(1, 8'h32, 1'b0);
    load(1, 8'h33, 1'b1); load(2, 8'h34, 1'b1);
    drain("lock");

    // Back-to-back same owner, GAP_CYCLES=0: restart 2 clocks after busy falls.
    tx_auto = 1'b0;
    @(negedge clk);
    push_exp(3, 8'h44); push_exp(3, 8'h45);
    load(3, 8'h44, 1'b1); load(3, 8'h45, 1'b1);
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (tx_send) break; end
    chk("b2b_send1", tx_send, 1);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin @(posedge clk); #1; cnt++; if (tx_send) break; end
    chk("b2b_restart", cnt, 2);
    @(negedge clk); tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    tx_auto = 1'b1;
    drain("b2b");

    // Start timeout with busy never rising.
    tx_auto = 1'b0;
    @(negedge clk);
    load(2, 8'h66, 1'b1);
    for (int c = 0; c < 50; c++) begin @(posedge clk); #1; if (tx_send) break; end
    chk("to_send_seen", tx_send, 1);
    hi = 1;
    for (int c = 0; c < 100; c++) begin @(posedge clk); #1; if (!tx_send) break; hi++; end
    chk("to_send_len", hi, 16);
    chk("to_err_pulse", timeout_err, 1);
    chk("to_grant", grant, 0);
    chk("to_no_ack", ack, 0);
    req[2] = 1'b0;
    @(posedge clk); #1;
    chk("to_err_once", timeout_err, 0);
    chk("to_idle_send", tx_send, 0);
    tx_auto = 1'b1;

    // Reset mid-frame while the transmitter stays busy.
    busy_len = 20;
    @(negedge clk);
    load(1, 8'h77, 1'b1);
    for (int c = 0; c < 50; c++) begin @(posedge clk); #2; if (ack != '0) break; end
    chk("rst_pre_ack", ack, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {ack, grant, tx_send, tx_data, timeout_err}, 0);
    @(negedge clk);
    busy_len = 6;
    push_exp(1, 8'h77); push_exp(3, 8'h73);
    load(3, 8'h73, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!tx_busy) break;
      if (tx_send) saw = 1'b1;
    end
    chk("rst_no_send_while_busy", saw, 0);
    chk("rst_busy_fell", tx_busy, 0);
    drain("rst_resume");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter between `NUM_REQ` byte producers. The block arbitrates round-robin with optional packet locking, drives `uart_tx`'s `send`/`data` handshake, and returns a per-requester acknowledge once the transmitter has accepted the byte. It sits directly in front of `uart_tx`. Its `tx_send`, `tx_data` and `tx_busy` connect to the transmitter's `send`, `data` and `busy`.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `GAP_CYCLES`, 0: idle clocks inserted after `tx_busy` falls before the next frame may start.
- `START_TIMEOUT`, 1024: clocks `tx_send` may stay high without `tx_busy` rising before the attempt is abandoned.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `req`  in  NUM_REQ  requester i has a byte pending; held high with stable data until `ack[i]`.
- `req_last`  in  NUM_REQ  the pending byte of requester i ends its packet.
- `req_data`  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- `ack`  out  NUM_REQ  one-cycle pulse: byte of requester i accepted by `uart_tx`.
- `grant`  out  NUM_REQ  one-hot current owner; zero when no owner.
- `tx_send`  out  1  to `uart_tx.send`.
- `tx_data`  out  8  to `uart_tx.data`; registered, stable from `tx_send` rise until `tx_busy` falls.
- `tx_busy`  in  1  from `uart_tx.busy`.
- `timeout_err`  out  1  one-cycle pulse: start attempt abandoned.

## Operation
- All outputs are registered.
- Reset values: `ack`=0, `grant`=0, `tx_send`=0, `tx_data`=8'h00, `timeout_err`=0.
- Reset also clears the FSM to IDLE, the lock to 0, the RR pointer to `NUM_REQ-1`, and the counter to 0.
- FSM states are IDLE, START, WAIT and GAP.
- IDLE
  - Arbitrate only when `tx_busy`=0 and `req`≠0.
  - If the lock is set and `req[owner]`=1, the owner wins.
  - If the lock is set and `req[owner]`=0, clear the lock and fall through to round-robin.
  - Round-robin: the first set `req` bit searching from pointer+1 upward, wrapping at `NUM_REQ-1`→0.
  - On a win: latch `tx_data`←`req_data[winner]`, set `grant`, set the pointer to the winner, and enter START.
- START: `tx_send`=1 and the counter increments each clock.
  - `tx_busy`=1 sampled: go to WAIT, `tx_send`←0, `ack[owner]` pulses for the one cycle WAIT is entered.
  - On that ack, the lock ← `req_last[owner]`==0.
  - Counter reaches `START_TIMEOUT-1` with no busy: go to IDLE and pulse `timeout_err`.
  - On timeout there is no ack, the lock is cleared, `grant`←0, and `tx_send`←0.
- WAIT: `tx_send`=0. When `tx_busy`=0, go to GAP if `GAP_CYCLES`>0, otherwise IDLE.
- GAP: count `GAP_CYCLES` clocks, then go to IDLE.
- On leaving WAIT/GAP to IDLE, `grant` stays set only while the lock is set; otherwise it goes to 0.
- Counter width is `$clog2(max(START_TIMEOUT, GAP_CYCLES)+1)`. The counter is cleared on every state entry.
- Changes to `req_data` after `ack` never affect the frame already in flight.

## Timing
- `req` rising in IDLE at edge n: `grant` and `tx_send` high after edge n+1.
- `tx_busy` sampled high at edge m: `tx_send` low and `ack` high after m+1; `ack` low after m+2.
- Back-to-back, same owner with `GAP_CYCLES`=0: the next `tx_send` rises 2 clocks after `tx_busy` falls (WAIT→IDLE, IDLE→START).
- Requests arriving in START/WAIT/GAP are only considered in IDLE. They are never dropped; they wait while `req` is held.
- `tx_busy` already high in IDLE (for example after a mid-frame reset, since `uart_tx` has no reset): no arbitration until it falls.
- Asynchronous reset mid-frame: `tx_send`, `ack` and `grant` drop immediately. The frame already shifting in `uart_tx` completes unmanaged.
- Simultaneous `req` edges: exactly one grant. No `ack` pulses for more than one requester in any cycle.

## Test plan
- Single byte: `req[0]`=1, `req_data[0]`=8'h28, `req_last`=1, with real `uart_tx` into a `uart_rx` loopback at 120 MHz clk → one `ack[0]` pulse, `uart_rx` delivers 8'h28, `grant` returns to 0.
- Round-robin: `req`=4'b1111 held with data 8'h10+i and all `req_last`=1 → acks in order 0,1,2,3,0. The rx byte sequence is 10,11,12,13,10.
- Packet lock: `req[1]` sends 3 bytes with `req_last`=0,0,1 while `req[0]` and `req[2]` stay high → the 3 bytes of requester 1 go out contiguously, then the grant goes to 2.
- Timeout: `tx_busy` tied 0, `START_TIMEOUT`=16 → `tx_send` high for 16 clocks, then one `timeout_err` pulse, no `ack`, FSM back in IDLE.
- Gap: `GAP_CYCLES`=50 with two queued bytes → exactly 50 + 2 clocks between `tx_busy` falling and the next `tx_send` rising.
- Reset mid-frame: deassert `rst_n` while `tx_busy`=1 → all outputs 0 immediately; after release, no `tx_send` until `tx_busy` falls, then normal arbitration resumes from requester 0.
